wishbone_arbiter: RTL

WISHBONE_ARBITER -- requirements
Module: wishbone_arbiter

---
 rtl/wishbone_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/wishbone_arbiter.sv
// Two-master Wishbone arbiter in front of one shared slave.
// Round-robin on ties, one idle cycle per handover, stall timeout.
module wishbone_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_rty_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_rty_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_rty_i
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_last;
  logic            r_to;
  logic [CW-1:0]   r_cnt;
  logic            w_tie;
  logic            w_term;
  logic            w_stall;

  assign w_tie   = m0_cyc_i & m1_cyc_i;
  assign w_term  = s_ack_i | s_err_i | s_rty_i;
  assign w_stall = s_cyc_o & s_stb_o & ~w_term;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_tie)         w_next = r_last ? OWN0 : OWN1;
        else if (m0_cyc_i) w_next = OWN0;
        else if (m1_cyc_i) w_next = OWN1;
        else               w_next = IDLE;
      end
      OWN0:    if (!m0_cyc_i) w_next = IDLE;
      OWN1:    if (!m1_cyc_i) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_sel_o  = '0;
    s_dat_o  = '0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_rty_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_rty_o = 1'b0;
    if (r_state == OWN0) begin
      s_cyc_o  = m0_cyc_i & ~r_to;
      s_stb_o  = m0_stb_i & ~r_to;
      s_we_o   = m0_we_i;
      s_adr_o  = m0_adr_i;
      s_sel_o  = m0_sel_i;
      s_dat_o  = m0_dat_i;
      m0_dat_o = s_dat_i;
      m0_ack_o = s_ack_i;
      m0_err_o = s_err_i | r_to;
      m0_rty_o = s_rty_i;
    end else if (r_state == OWN1) begin
      s_cyc_o  = m1_cyc_i & ~r_to;
      s_stb_o  = m1_stb_i & ~r_to;
      s_we_o   = m1_we_i;
      s_adr_o  = m1_adr_i;
      s_sel_o  = m1_sel_i;
      s_dat_o  = m1_dat_i;
      m1_dat_o = s_dat_i;
      m1_ack_o = s_ack_i;
      m1_err_o = s_err_i | r_to;
      m1_rty_o = s_rty_i;
    end
  end

  // r_to marks the single forced-error cycle after TIMEOUT stalled strobes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_cnt   <= '0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_tie) r_last <= ~r_last;
      r_to <= 1'b0;
      if (!w_stall) begin
        r_cnt <= '0;
      end else if (r_cnt == LIM) begin
        r_cnt <= '0;
        r_to  <= 1'b1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule
